hbridge_driver: RTL and testbench

HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

---
 rtl/drive_pkg.sv | 24 ++
 rtl/hb_leg.sv | 56 +++++
 rtl/hbridge_driver.sv | 154 +++++++++++++++
 tb/tb_hbridge_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types for the H-bridge gate driver.
//
// Contents:
//   drive_state_t : 3-bit encoding of the bridge controller FSM states
//   leg_req_t     : what the controller asks one half-bridge leg to do
//                   (both switches off, high-side on, low-side on)
package drive_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        REV    = 3'd2,
        SWITCH = 3'd3,
        BRAKE  = 3'd4,
        FAULT  = 3'd5
    } drive_state_t;

    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_H   = 2'd1,
        LEG_L   = 2'd2
    } leg_req_t;

endpackage

// File: rtl/hb_leg.sv
// One half-bridge leg with dead-time insertion.
//
// A switch turns off in the same edge its request goes away, but it only
// turns on once the complementary switch has been off for DEAD_TIME_CYC
// cycles. Each off-counter saturates at DEAD_TIME_CYC and is preset there
// on reset so the first turn-on after reset is not delayed.
//
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   req     : requested leg state (LEG_OFF / LEG_H / LEG_L)
//   gate_h  : registered high-side gate drive
//   gate_l  : registered low-side gate drive
module hb_leg
    import drive_pkg::*;
#(
    parameter int DEAD_TIME_CYC = 10
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  leg_req_t req,
    output logic     gate_h,
    output logic     gate_l
);

    localparam int CW = $clog2(DEAD_TIME_CYC + 1);
    localparam logic [CW-1:0] DT = CW'(DEAD_TIME_CYC);

    // Number of consecutive cycles each gate has been low, present cycle included.
    logic [CW-1:0] h_off_cnt;
    logic [CW-1:0] l_off_cnt;
    logic          h_next;
    logic          l_next;

    // A counter at DT implies its gate is currently low, so the two enables
    // can never both be true and a short request never produces a pulse.
    always_comb begin
        h_next = (req == LEG_H) && (l_off_cnt == DT);
        l_next = (req == LEG_L) && (h_off_cnt == DT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gate_h    <= 1'b0;
            gate_l    <= 1'b0;
            h_off_cnt <= DT;
            l_off_cnt <= DT;
        end else begin
            gate_h    <= h_next;
            gate_l    <= l_next;
            h_off_cnt <= h_next ? '0 : ((h_off_cnt == DT) ? DT : h_off_cnt + CW'(1));
            l_off_cnt <= l_next ? '0 : ((l_off_cnt == DT) ? DT : l_off_cnt + CW'(1));
        end
    end

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge gate driver: direction/PWM sequencing, reversal coast, fault latch
// and per-leg dead time.
//
// Optional feature: define HBRIDGE_BRAKE_EN to compile in the BRAKE state
// (both low-sides on when enable drops). Without it, enable=0 coasts via IDLE.
//
// Ports:
//   clk_i, reset_i          : clock and synchronous active-high reset
//   enable_i                : drive enable
//   pwm_i                   : PWM from the position controller
//   direction_i             : 1 = forward (leg A switching, leg B low), 0 = reverse
//   fault_i                 : overcurrent comparator, active high
//   gate_ah_o .. gate_bl_o  : registered gate drives of legs A and B
//   fault_o                 : latched-fault flag
//   state_o                 : current FSM state
module hbridge_driver
    import drive_pkg::*;
#(
    parameter int DEAD_TIME_CYC = 10,
    parameter int REVERSE_CYC   = 256
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       pwm_i,
    input  logic       direction_i,
    input  logic       fault_i,
    output logic       gate_ah_o,
    output logic       gate_al_o,
    output logic       gate_bh_o,
    output logic       gate_bl_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam int RW = $clog2(REVERSE_CYC + 1);
    localparam logic [RW-1:0] RC = RW'(REVERSE_CYC);

`ifdef HBRIDGE_BRAKE_EN
    localparam drive_state_t DISABLE_STATE = BRAKE;
`else
    localparam drive_state_t DISABLE_STATE = IDLE;
`endif

    logic         en_q, pwm_q, dir_q, flt_q;
    logic         dir_d;
    drive_state_t state_q, state_next;
    logic [RW-1:0] rev_cnt;
    leg_req_t     req_a, req_b;

    // Input registers; dir_d is one cycle older so a direction change can be
    // seen while coasting in SWITCH.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q  <= 1'b0;
            pwm_q <= 1'b0;
            dir_q <= 1'b0;
            flt_q <= 1'b0;
            dir_d <= 1'b0;
        end else begin
            en_q  <= enable_i;
            pwm_q <= pwm_i;
            dir_q <= direction_i;
            flt_q <= fault_i;
            dir_d <= dir_q;
        end
    end

    // Next-state logic. Disable beats a direction change; fault beats everything.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:   if (en_q) state_next = dir_q ? FWD : REV;
            FWD:    if (!en_q) state_next = DISABLE_STATE;
                    else if (!dir_q) state_next = SWITCH;
            REV:    if (!en_q) state_next = DISABLE_STATE;
                    else if (dir_q) state_next = SWITCH;
            SWITCH: if (!en_q) state_next = DISABLE_STATE;
                    else if ((dir_q == dir_d) && (rev_cnt == RC)) state_next = dir_q ? FWD : REV;
`ifdef HBRIDGE_BRAKE_EN
            BRAKE:  if (en_q) state_next = IDLE;
`endif
            FAULT:  if (!flt_q && !en_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flt_q) state_next = FAULT;
    end

    // Leg requests follow the state being entered, so the gate registers
    // update on the same edge as the state register.
    always_comb begin
        req_a = LEG_OFF;
        req_b = LEG_OFF;
        case (state_next)
            FWD: begin
                req_a = pwm_q ? LEG_H : LEG_L;
                req_b = LEG_L;
            end
            REV: begin
                req_a = LEG_L;
                req_b = pwm_q ? LEG_H : LEG_L;
            end
`ifdef HBRIDGE_BRAKE_EN
            BRAKE: begin
                req_a = LEG_L;
                req_b = LEG_L;
            end
`endif
            default: begin
                req_a = LEG_OFF;
                req_b = LEG_OFF;
            end
        endcase
    end

    // State, fault flag and reversal counter. The counter holds the number of
    // coast cycles elapsed including the current one, and restarts at 1 on
    // entry or on a further direction change.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            fault_o <= 1'b0;
            rev_cnt <= '0;
        end else begin
            state_q <= state_next;
            fault_o <= (state_next == FAULT);
            if (state_next == SWITCH) begin
                if ((state_q != SWITCH) || (dir_q != dir_d))
                    rev_cnt <= RW'(1);
                else if (rev_cnt != RC)
                    rev_cnt <= rev_cnt + RW'(1);
            end
        end
    end

    assign state_o = state_q;

    hb_leg #(.DEAD_TIME_CYC(DEAD_TIME_CYC)) u_leg_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req     (req_a),
        .gate_h  (gate_ah_o),
        .gate_l  (gate_al_o)
    );

    hb_leg #(.DEAD_TIME_CYC(DEAD_TIME_CYC)) u_leg_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req     (req_b),
        .gate_h  (gate_bh_o),
        .gate_l  (gate_bl_o)
    );

endmodule

// File: tb/tb_hbridge_driver.sv
// Self-checking bench for hbridge_driver with DEAD_TIME_CYC=4, REVERSE_CYC=16.
// Expected output vectors {state, fault, ah, al, bh, bl} are queued with the
// edge number at which they must appear, then compared on the falling edge.
module tb_hbridge_driver;
    import drive_pkg::*;

    localparam logic [7:0] M_ALL   = 8'hFF;
    localparam logic [7:0] M_GATES = 8'h0F;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i, pwm_i, direction_i, fault_i;
    logic       gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o, fault_o;
    logic [2:0] state_o;

    int cyc = 0;
    int vectorCount = 0;
    int missCount = 0;

    int         sbAt[$];
    logic [7:0] sbExp[$];
    logic [7:0] sbMask[$];
    string      sbTag[$];

    hbridge_driver #(.DEAD_TIME_CYC(4), .REVERSE_CYC(16)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .pwm_i       (pwm_i),
        .direction_i (direction_i),
        .fault_i     (fault_i),
        .gate_ah_o   (gate_ah_o),
        .gate_al_o   (gate_al_o),
        .gate_bh_o   (gate_bh_o),
        .gate_bl_o   (gate_bl_o),
        .fault_o     (fault_o),
        .state_o     (state_o)
    );

    // Free-running clock and an edge counter used as the scoreboard timebase.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] packVec(input drive_state_t st, input logic flt, input logic [3:0] g);
        return {st, flt, g};
    endfunction

    task automatic pushExpect(input int at, input string tag, input logic [7:0] exp, input logic [7:0] mask);
        sbAt.push_back(at);
        sbExp.push_back(exp);
        sbMask.push_back(mask);
        sbTag.push_back(tag);
    endtask

    task automatic applyStimulus(input logic en, input logic dir, input logic pwm, input logic flt);
        enable_i    = en;
        direction_i = dir;
        pwm_i       = pwm;
        fault_i     = flt;
    endtask

    task automatic stepClock(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Compare every queued vector that is due at this edge, plus the
    // shoot-through invariants on every cycle after the first edge.
    always @(negedge clk_i) begin
        logic [7:0] obs;
        obs = {state_o, fault_o, gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o};
        if (cyc >= 1)
            checkOutput("overlap", {5'b0, gate_ah_o & gate_al_o, gate_bh_o & gate_bl_o,
                                    gate_ah_o & gate_bh_o}, 8'h00);
        for (int i = sbAt.size() - 1; i >= 0; i--) begin
            if (sbAt[i] == cyc) begin
                checkOutput(sbTag[i], obs & sbMask[i], sbExp[i] & sbMask[i]);
                sbAt.delete(i);
                sbExp.delete(i);
                sbMask.delete(i);
                sbTag.delete(i);
            end
        end
    end

    initial begin
        int e;
        reset_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepClock(1);

        // Reset state
        pushExpect(cyc + 1, "reset_state", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        stepClock(1);

        // Release reset straight into forward drive with pwm high
        e = cyc;
        reset_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pushExpect(e + 1, "startup_idle", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        pushExpect(e + 2, "startup_fwd",  packVec(FWD,  1'b0, 4'b1001), M_ALL);
        stepClock(4);

        // pwm 1->0: ah drops at +2, al rises 4 cycles later
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pushExpect(e + 1, "pwm_fall_hold", packVec(FWD, 1'b0, 4'b1001), M_ALL);
        for (int k = 2; k <= 5; k++)
            pushExpect(e + k, "pwm_fall_dead", packVec(FWD, 1'b0, 4'b0001), M_ALL);
        pushExpect(e + 6, "pwm_fall_al_on", packVec(FWD, 1'b0, 4'b0101), M_ALL);
        stepClock(8);

        // 2-cycle pwm pulse, shorter than dead time: no ah pulse
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pushExpect(e + 1, "short_pulse_pre", packVec(FWD, 1'b0, 4'b0101), M_ALL);
        pushExpect(e + 2, "short_pulse_a",   packVec(FWD, 1'b0, 4'b0001), M_ALL);
        pushExpect(e + 3, "short_pulse_b",   packVec(FWD, 1'b0, 4'b0001), M_ALL);
        for (int k = 4; k <= 7; k++)
            pushExpect(e + k, "short_pulse_post", packVec(FWD, 1'b0, 4'b0101), M_ALL);
        stepClock(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepClock(8);

        // pwm 0->1: al off at +2, ah on after dead time
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 5; k++)
            pushExpect(e + k, "pwm_rise_dead", packVec(FWD, 1'b0, 4'b0001), M_ALL);
        pushExpect(e + 6, "pwm_rise_ah_on", packVec(FWD, 1'b0, 4'b1001), M_ALL);
        stepClock(8);

        // Reversal forward -> reverse: 16 coast cycles, then REV pattern
        e = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 2; k <= 17; k++)
            pushExpect(e + k, "reverse_coast", packVec(SWITCH, 1'b0, 4'b0000), M_ALL);
        pushExpect(e + 18, "reverse_rev", packVec(REV, 1'b0, 4'b0110), M_ALL);
        stepClock(20);

        // Reversal with a second toggle 8 cycles in: coast count restarts
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 25; k++)
            pushExpect(e + k, "restart_coast", packVec(SWITCH, 1'b0, 4'b0000), M_ALL);
        pushExpect(e + 26, "restart_rev", packVec(REV, 1'b0, 4'b0110), M_ALL);
        stepClock(8);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        stepClock(20);

        // Fault pulse together with a direction change: fault wins, latches
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 2; k <= 7; k++)
            pushExpect(e + k, "fault_latched", packVec(FAULT, 1'b1, 4'b0000), M_ALL);
        pushExpect(e + 8, "fault_cleared", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        stepClock(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepClock(4);

        // Re-enable forward
        e = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pushExpect(e + 1, "reenable_idle", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        pushExpect(e + 2, "reenable_fwd",  packVec(FWD,  1'b0, 4'b1001), M_ALL);
        stepClock(6);

        // Enable 1->0 while driving
        e = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HBRIDGE_BRAKE_EN
        for (int k = 2; k <= 5; k++)
            pushExpect(e + k, "brake_dead", packVec(BRAKE, 1'b0, 4'b0001), M_ALL);
        pushExpect(e + 6, "brake_low", packVec(BRAKE, 1'b0, 4'b0101), M_ALL);
`else
        for (int k = 2; k <= 5; k++)
            pushExpect(e + k, "disable_coast", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
`endif
        stepClock(8);

        // Mid-operation reset, then immediate turn-on after release
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        stepClock(10);
        e = cyc;
        reset_i = 1'b1;
        pushExpect(e + 1, "midrun_reset", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        stepClock(2);
        e = cyc;
        reset_i = 1'b0;
        pushExpect(e + 1, "post_reset_idle", packVec(IDLE, 1'b0, 4'b0000), M_ALL);
        pushExpect(e + 2, "post_reset_fwd",  packVec(FWD,  1'b0, 4'b1001), M_GATES);
        stepClock(4);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 40 && sbAt.size() != 0; i++)
            stepClock(1);
        checkOutput("scoreboard_drain", 8'(sbAt.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
